// File: rtl/led_arbiter_if.sv
`default_nettype none
// ------------------------------------------------------------------
// led_arbiter_if: requester-side bundle of the LEDG arbiter. Rev 1.0
// ------------------------------------------------------------------
interface led_arbiter_if;
  logic [3:0]  req;
  logic [31:0] pat;
  logic [3:0]  blink;
  logic [3:0]  gnt;
  logic [7:0]  LEDG;
  logic        tick;

  modport master (output req, pat, blink, input gnt, LEDG, tick);
  modport slave  (input req, pat, blink, output gnt, LEDG, tick);
endinterface
`default_nettype wire

// File: rtl/led_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// led_arbiter: round-robin owner of the 8 LEDG pins with prescaled tick,
// time slices and blink. LED_ARB_HEARTBEAT_EN: idle LED0 follows phase. Rev 1.0
// ------------------------------------------------------------------
module led_arbiter #(
  parameter int CLK_HZ      = 50000000,
  parameter int TICK_HZ     = 2,
  parameter int SLICE_TICKS = 4
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  led_arbiter_if.slave bus
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int SLC_W = $clog2(SLICE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [SLC_W-1:0] SLC_MAX = SLC_W'(SLICE_TICKS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_OWN    = 2'd1,
    S_SWITCH = 2'd2
  } state_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             phase_q, phase_d;

  state_e           state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       own_q;
  logic [SLC_W-1:0] slice_q;
  logic [3:0]       gnt_q;
  logic [7:0]       led_q;

  logic             win_found;
  logic [1:0]       win_idx;
  logic [7:0]       win_led;
  logic [7:0]       own_led;
  logic [7:0]       idle_led;
  logic             others_req;
  logic             release_now;

  // Free-running prescaler; phase flips on the same edge tick is raised.
  always_comb begin
    tick_d  = (cnt_q == CNT_MAX);
    cnt_d   = tick_d ? '0 : cnt_q + CNT_W'(1);
    phase_d = phase_q ^ tick_d;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
    end
  end

  // Search starts one past the last owner, so the last owner is tried last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      if (!win_found && bus.req[ptr_q + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    win_led     = (bus.blink[win_idx] && phase_q) ? 8'h00 : bus.pat[{win_idx, 3'b000} +: 8];
    own_led     = (bus.blink[own_q] && phase_q) ? 8'h00 : bus.pat[{own_q, 3'b000} +: 8];
    others_req  = |(bus.req & ~(4'b0001 << own_q));
    release_now = !bus.req[own_q] || ((slice_q == SLC_MAX) && others_req);
`ifdef LED_ARB_HEARTBEAT_EN
    idle_led    = {7'b0, phase_q};
`else
    idle_led    = 8'h00;
`endif
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd3;
      own_q   <= 2'd0;
      slice_q <= '0;
      gnt_q   <= 4'b0000;
      led_q   <= 8'h00;
    end else begin
      case (state_q)
        S_IDLE, S_SWITCH: begin
          if (win_found) begin
            state_q <= S_OWN;
            own_q   <= win_idx;
            gnt_q   <= 4'b0001 << win_idx;
            led_q   <= win_led;
            slice_q <= '0;
          end else begin
            state_q <= S_IDLE;
            gnt_q   <= 4'b0000;
            led_q   <= idle_led;
          end
        end
        S_OWN: begin
          if (release_now) begin
            state_q <= S_SWITCH;
            gnt_q   <= 4'b0000;
            led_q   <= 8'h00;
            ptr_q   <= own_q;
          end else begin
            led_q <= own_led;
            // An uncontended expired slice restarts instead of releasing.
            if (slice_q == SLC_MAX) begin
              slice_q <= '0;
            end else if (tick_q) begin
              slice_q <= slice_q + SLC_W'(1);
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          gnt_q   <= 4'b0000;
          led_q   <= 8'h00;
        end
      endcase
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.LEDG = led_q;
  assign bus.tick = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_led_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_led_arbiter: directed vectors and corner sequences, DIV=4, SLICE_TICKS=2. Rev 1.0
// ------------------------------------------------------------------
module tb_led_arbiter;

  logic clk = 1'b0;
  logic reset;

  led_arbiter_if bus();

  led_arbiter #(
    .CLK_HZ      (40),
    .TICK_HZ     (10),
    .SLICE_TICKS (2)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] pat;
    logic [3:0]  blink;
    logic [3:0]  gnt;
    logic [7:0]  led;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the bench at the negedge right after the reset edge.
  task automatic do_reset();
    reset     = 1'b1;
    bus.req   = 4'b0;
    bus.pat   = 32'h0;
    bus.blink = 4'b0;
    step();
    reset = 1'b0;
  endtask

  // Phase value after the n-th edge following the reset edge.
  function automatic logic ph(input int m);
    return ((m / 4) % 2) == 1;
  endfunction

  function automatic logic [7:0] idle_exp(input int n);
`ifdef LED_ARB_HEARTBEAT_EN
    return {7'b0, ph(n - 1)};
`else
    return 8'h00;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rr_g [4];
    logic [7:0] rr_l [3];
    int         len;
    int         bad;

    vecs[0] = '{4'b0001, 32'h4433_2211, 4'b0000, 4'b0001, 8'h11};
    vecs[1] = '{4'b0100, 32'h44A5_2211, 4'b0000, 4'b0100, 8'hA5};
    vecs[2] = '{4'b1000, 32'h4433_2211, 4'b0000, 4'b1000, 8'h44};
    vecs[3] = '{4'b1110, 32'h4433_2211, 4'b0000, 4'b0010, 8'h22};
    vecs[4] = '{4'b1100, 32'h4433_2211, 4'b0000, 4'b0100, 8'h33};
    vecs[5] = '{4'b1111, 32'h4433_2211, 4'b0000, 4'b0001, 8'h11};
    vecs[6] = '{4'b0000, 32'h4433_2211, 4'b0000, 4'b0000, 8'h00};
    vecs[7] = '{4'b0010, 32'h4433_2211, 4'b0010, 4'b0010, 8'h22};

    reset     = 1'b1;
    bus.req   = 4'hF;
    bus.pat   = 32'h0;
    bus.blink = 4'b0;
    @(negedge clk);

    // Reset held with all requests asserted
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_gnt", 32'(bus.gnt), 32'h0);
      check("rst_led", 32'(bus.LEDG), 32'h0);
      check("rst_tick", 32'(bus.tick), 32'h0);
    end
    reset   = 1'b0;
    bus.req = 4'h0;
    for (int n = 1; n <= 12; n++) begin
      step();
      check("tick_period", 32'(bus.tick), 32'(n % 4 == 0));
    end

    // First-grant vectors from a fresh reset
    for (int i = 0; i < 8; i++) begin
      do_reset();
      bus.req   = vecs[i].req;
      bus.pat   = vecs[i].pat;
      bus.blink = vecs[i].blink;
      step();
      check($sformatf("vec%0d_gnt", i), 32'(bus.gnt), 32'(vecs[i].gnt));
      check($sformatf("vec%0d_led", i), 32'(bus.LEDG), 32'(vecs[i].led));
    end

    // Single uncontended owner keeps the grant across many ticks
    do_reset();
    bus.req = 4'b0100;
    bus.pat = 32'h00A5_0000;
    step();
    check("single_gnt", 32'(bus.gnt), 32'h4);
    check("single_led", 32'(bus.LEDG), 32'hA5);
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (bus.gnt !== 4'b0100 || bus.LEDG !== 8'hA5) bad++;
    end
    check("single_hold_bad_cycles", 32'(bad), 32'h0);

    // Reset in the middle of a grant
    reset = 1'b1;
    step();
    check("midrst_gnt", 32'(bus.gnt), 32'h0);
    check("midrst_led", 32'(bus.LEDG), 32'h0);
    check("midrst_tick", 32'(bus.tick), 32'h0);
    reset = 1'b0;

    // Round-robin among 0,1,3
    rr_g[0] = 4'b0001; rr_g[1] = 4'b0010; rr_g[2] = 4'b1000; rr_g[3] = 4'b0001;
    rr_l[0] = 8'h01;   rr_l[1] = 8'h02;   rr_l[2] = 8'h08;
    do_reset();
    bus.req = 4'b1011;
    bus.pat = 32'h0800_0201;
    step();
    for (int t = 0; t < 3; t++) begin
      check($sformatf("rr%0d_gnt", t), 32'(bus.gnt), 32'(rr_g[t]));
      len = 0;
      bad = 0;
      while (bus.gnt === rr_g[t] && len < 20) begin
        if (bus.LEDG !== rr_l[t]) bad++;
        len++;
        step();
      end
      check($sformatf("rr%0d_led_bad_cycles", t), 32'(bad), 32'h0);
      check($sformatf("rr%0d_len_in_5_9(len=%0d)", t, len), 32'(len >= 5 && len <= 9), 32'h1);
      check($sformatf("rr%0d_gap_gnt", t), 32'(bus.gnt), 32'h0);
      check($sformatf("rr%0d_gap_led", t), 32'(bus.LEDG), 32'h0);
      step();
    end
    check("rr3_gnt", 32'(bus.gnt), 32'(rr_g[3]));

    // Early release hands over after one gap cycle
    do_reset();
    bus.req = 4'b0101;
    bus.pat = 32'h0033_0011;
    step();
    check("early_gnt0", 32'(bus.gnt), 32'h1);
    check("early_led0", 32'(bus.LEDG), 32'h11);
    step();
    step();
    bus.req = 4'b0100;
    step();
    check("early_gap_gnt", 32'(bus.gnt), 32'h0);
    check("early_gap_led", 32'(bus.LEDG), 32'h0);
    step();
    check("early_gnt2", 32'(bus.gnt), 32'h4);
    check("early_led2", 32'(bus.LEDG), 32'h33);

    // Blink follows phase one cycle after each tick
    do_reset();
    bus.req   = 4'b0010;
    bus.pat   = 32'h0000_FF00;
    bus.blink = 4'b0010;
    for (int n = 1; n <= 20; n++) begin
      step();
      check($sformatf("blink_led_n%0d", n), 32'(bus.LEDG), ph(n - 1) ? 32'h00 : 32'hFF);
      check($sformatf("blink_tick_n%0d", n), 32'(bus.tick), 32'(n % 4 == 0));
    end

    // Idle LED value with no requests
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      step();
      check($sformatf("idle_led_n%0d", n), 32'(bus.LEDG), 32'(idle_exp(n)));
      check($sformatf("idle_gnt_n%0d", n), 32'(bus.gnt), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
